// File: rtl/gradient_pkg.sv
// Shared constants for the 3x3 gradient engine: mode encoding, kernel weights
// and the gradient width derivation.
package gradient_pkg;

   localparam logic MODE_SOBEL   = 1'b0;
   localparam logic MODE_PREWITT = 1'b1;

   // Centre-row/column weight; the corner weights are always 1.
   localparam int SOBEL_CTR   = 2;
   localparam int PREWITT_CTR = 1;

   // Window rows/cols that must have been seen before a window is complete.
   localparam int WIN_LAG = 2;

   // 8*(2^DATA_W-1) < 2^(DATA_W+3): fits both signed Gx/Gy and unsigned |Gx|+|Gy|.
   function automatic int grad_w(input int data_w);
      return data_w + 3;
   endfunction

endpackage

// File: rtl/gradient_mag_abs.sv
// Second pipeline stage: |Gx|+|Gy|, strict threshold compare, registered outputs.
// Output data holds while no valid pixel arrives.
module gradient_mag_abs #(
   parameter int GRAD_W = 15
) (
   input  logic                     iCLK,
   input  logic                     iRST,
   input  logic                     iVLD,
   input  logic                     iBORDER,
   input  logic signed [GRAD_W-1:0] iGX,
   input  logic signed [GRAD_W-1:0] iGY,
   input  logic        [GRAD_W-1:0] iTHRESH,
   output logic signed [GRAD_W-1:0] oGX,
   output logic signed [GRAD_W-1:0] oGY,
   output logic        [GRAD_W-1:0] oMAG,
   output logic                     oEDGE,
   output logic                     oBORDER,
   output logic                     oDVAL
);

   logic [GRAD_W-1:0] abs_gx, abs_gy, mag;

   // Most-negative value is unreachable, so plain negate cannot overflow.
   assign abs_gx = iGX[GRAD_W-1] ? GRAD_W'(-iGX) : GRAD_W'(iGX);
   assign abs_gy = iGY[GRAD_W-1] ? GRAD_W'(-iGY) : GRAD_W'(iGY);
   assign mag    = abs_gx + abs_gy;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         oGX     <= '0;
         oGY     <= '0;
         oMAG    <= '0;
         oEDGE   <= 1'b0;
         oBORDER <= 1'b0;
         oDVAL   <= 1'b0;
      end else begin
         oDVAL <= iVLD;
         if (iVLD) begin
            oGX     <= iGX;
            oGY     <= iGY;
            oMAG    <= mag;
            oEDGE   <= ~iBORDER & (mag > iTHRESH);
            oBORDER <= iBORDER;
         end
      end
   end

endmodule

// File: rtl/gradient_conv_3x3.sv
// 3x3 Sobel/Prewitt gradient engine: window columns, col/line border counters,
// per-frame mode latch and stage-1 Gx/Gy registers feeding the magnitude stage.
module gradient_conv_3x3
   import gradient_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int IMG_W  = 640,
   parameter int GRAD_W = grad_w(DATA_W)
) (
   input  logic                     iCLK,
   input  logic                     iRST,
   input  logic        [DATA_W-1:0] iRow0,
   input  logic        [DATA_W-1:0] iRow1,
   input  logic        [DATA_W-1:0] iRow2,
   input  logic                     iDVAL,
   input  logic                     iSOF,
   input  logic                     iMODE,
   input  logic        [GRAD_W-1:0] iTHRESH,
   output logic signed [GRAD_W-1:0] oGX,
   output logic signed [GRAD_W-1:0] oGY,
   output logic        [GRAD_W-1:0] oMAG,
   output logic                     oEDGE,
   output logic                     oBORDER,
   output logic                     oDVAL
);

   localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 2;

   // Index 0 = bottom (newest) row, index 2 = top (oldest) row.
   typedef logic [2:0][DATA_W-1:0] column_t;

   typedef struct packed {
      logic                     vld;
      logic                     border;
      logic signed [GRAD_W-1:0] gx;
      logic signed [GRAD_W-1:0] gy;
      logic        [GRAD_W-1:0] thresh;
   } stage1_t;

   column_t                  taps, c1, c2;
   logic        [COL_W-1:0]  col_r, cur_col;
   logic        [1:0]        line_r, cur_line;
   logic                     mode_r, cur_mode;
   logic                     border;
   logic signed [GRAD_W-1:0] gx, gy;
   stage1_t                  s1;

   assign taps = {iRow2, iRow1, iRow0};

   // Weighted 1-2-1 (Sobel) or 1-1-1 (Prewitt) sum of three pixels.
   function automatic logic signed [GRAD_W-1:0] wsum(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b,
                                                     input logic [DATA_W-1:0] c,
                                                     input logic              m);
      logic signed [GRAD_W-1:0] ea, eb, ec;
      ea = GRAD_W'(a);
      eb = GRAD_W'(b);
      ec = GRAD_W'(c);
      if (m == MODE_PREWITT) eb = GRAD_W'(eb * PREWITT_CTR);
      else                   eb = GRAD_W'(eb * SOBEL_CTR);
      return ea + eb + ec;
   endfunction

   // Position/mode of the pixel being accepted; a qualified SOF overrides the counters.
   always_comb begin
      cur_col  = col_r;
      cur_line = line_r;
      cur_mode = mode_r;
      if (iSOF) begin
         cur_col  = '0;
         cur_line = '0;
         cur_mode = iMODE;
      end
   end

   assign border = ~((cur_col >= COL_W'(WIN_LAG)) && (cur_line >= 2'(WIN_LAG)));

   // Left column = c2 (oldest), right column = live taps.
   assign gx = wsum(taps[2], taps[1], taps[0], cur_mode) - wsum(c2[2], c2[1], c2[0], cur_mode);
   assign gy = wsum(c2[0], c1[0], taps[0], cur_mode) - wsum(c2[2], c1[2], taps[2], cur_mode);

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         col_r  <= '0;
         line_r <= '0;
         mode_r <= MODE_SOBEL;
         c1     <= '0;
         c2     <= '0;
         s1     <= '0;
      end else begin
         s1.vld <= iDVAL;
         if (iDVAL) begin
            c2     <= c1;
            c1     <= taps;
            mode_r <= cur_mode;
            if (cur_col == COL_W'(IMG_W-1)) begin
               col_r  <= '0;
               line_r <= (cur_line == 2'(WIN_LAG)) ? cur_line : cur_line + 2'd1;
            end else begin
               col_r  <= cur_col + 1'b1;
               line_r <= cur_line;
            end
            s1.border <= border;
            s1.gx     <= border ? '0 : gx;
            s1.gy     <= border ? '0 : gy;
            s1.thresh <= iTHRESH;
         end
      end
   end

   gradient_mag_abs #(.GRAD_W(GRAD_W)) u_mag (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .iVLD    (s1.vld),
      .iBORDER (s1.border),
      .iGX     (s1.gx),
      .iGY     (s1.gy),
      .iTHRESH (s1.thresh),
      .oGX     (oGX),
      .oGY     (oGY),
      .oMAG    (oMAG),
      .oEDGE   (oEDGE),
      .oBORDER (oBORDER),
      .oDVAL   (oDVAL)
   );

endmodule
